interp_fir_tx: RTL

//  Transmit-path counterpart of the receive lowpass FIR: polyphase x L interpolating anti-imaging FIR.

---
 rtl/interp_fir_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/interp_fir_tx.sv
// Polyphase x L interpolating anti-imaging FIR for the sonar transmit path; one time-shared MAC, one sample in flight.
// Define INTERP_FIR_SAT_EN to clamp the shifted accumulator to 24 bits; otherwise the low 24 bits are kept (wrap).
module interp_fir_tx #(
  parameter int L       = 4,
  parameter int TAPS    = 64,
  parameter int CH_BITS = 3,
  parameter int SHIFT   = 20,
  // Prototype coefficients h[0..TAPS-1], signed 24-bit, h[i] at bits [i*24 +: 24] (built from interp_coe.mem)
  parameter logic [TAPS*24-1:0] COEFS = '0
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_arst,
  input  logic [23:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [CH_BITS-1:0] s_axis_tuser,
  input  logic               s_axis_tlast,
  output logic [23:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [CH_BITS-1:0] m_axis_tuser,
  output logic               m_axis_tlast
);

  localparam int NP    = TAPS / L;
  localparam int NPW   = $clog2(NP);
  localparam int LW    = $clog2(L);
  localparam int AW    = CH_BITS + NPW;
  localparam int ACC_W = 48 + NPW;
  localparam int MW    = NPW + 2;
  localparam logic [MW-1:0] MAC_LAST = MW'(NP + 2);
  localparam logic [MW-1:0] MAC_RDS  = MW'(NP);
  localparam logic [LW-1:0] PH_LAST  = LW'(L - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_MAC, S_OUT} state_t;
  state_t state, state_nxt;

  logic [23:0]               mem [2**AW];
  logic [NPW-1:0]            ptr [2**CH_BITS];
  logic [AW-1:0]             init_cnt;
  logic [MW-1:0]             mac_cnt;
  logic [LW-1:0]             phase;
  logic [CH_BITS-1:0]        ch_q;
  logic                      last_q;
  logic signed [23:0]        rd_data, coef_q;
  logic signed [47:0]        prod;
  logic                      rd_vld, prod_vld;
  logic signed [ACC_W-1:0]   accum;
  logic [23:0]               out_word;
  logic                      in_hs, out_hs, rd_en;
  logic [NPW-1:0]            rd_k;
  logic [NPW+LW-1:0]         coef_idx;

  assign in_hs    = (state == S_IDLE) && s_axis_tvalid;
  assign out_hs   = (state == S_OUT) && m_axis_tready;
  assign rd_en    = (state == S_MAC) && (mac_cnt < MAC_RDS);
  assign rd_k     = mac_cnt[NPW-1:0];
  assign coef_idx = {rd_k, phase};

  // NOTE: sequential state uses <= so every flop samples the values from before the edge.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) state <= S_INIT;
    else             state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    state_nxt = state;
    unique case (state)
      S_INIT: if (init_cnt == '1)        state_nxt = S_IDLE;
      S_IDLE: if (s_axis_tvalid)         state_nxt = S_MAC;
      S_MAC:  if (mac_cnt == MAC_LAST)   state_nxt = S_OUT;
      S_OUT:  if (m_axis_tready)         state_nxt = (phase == PH_LAST) ? S_IDLE : S_MAC;
      default:                           state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    s_axis_tready = (state == S_IDLE);
    m_axis_tvalid = (state == S_OUT);
    m_axis_tlast  = (state == S_OUT) && last_q && (phase == PH_LAST);
  end

  assign m_axis_tuser = ch_q;

  // NOTE: the delay-line RAM has no reset; INIT zero-fills it so it can map onto block RAM.
  always_ff @(posedge s_axis_aclk) begin
    if (state == S_INIT) mem[init_cnt] <= '0;
    else if (in_hs)      mem[{s_axis_tuser, ptr[s_axis_tuser]}] <= s_axis_tdata;
    if (rd_en)           rd_data <= mem[{ch_q, ptr[ch_q] - rd_k}];
  end

  // Coefficient fetch runs alongside the RAM read so both operands arrive together.
  always_ff @(posedge s_axis_aclk) begin
    coef_q <= COEFS[int'(coef_idx)*24 +: 24];
    prod   <= rd_data * coef_q;
  end

`ifdef INTERP_FIR_SAT_EN
  logic signed [ACC_W-1:0] shifted;
  assign shifted = accum >>> SHIFT;
  always_comb begin
    out_word = shifted[23:0];
    if (!(&shifted[ACC_W-1:23]) && (|shifted[ACC_W-1:23]))
      out_word = shifted[ACC_W-1] ? 24'h800000 : 24'h7FFFFF;
  end
`else
  assign out_word = 24'(accum >>> SHIFT);
`endif

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      init_cnt     <= '0;
      mac_cnt      <= '0;
      phase        <= '0;
      ch_q         <= '0;
      last_q       <= 1'b0;
      rd_vld       <= 1'b0;
      prod_vld     <= 1'b0;
      accum        <= '0;
      m_axis_tdata <= '0;
      for (int i = 0; i < 2**CH_BITS; i++) ptr[i] <= '0;
    end else begin
      rd_vld   <= rd_en;
      prod_vld <= rd_vld;
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
      if (in_hs) begin
        ch_q   <= s_axis_tuser;
        last_q <= s_axis_tlast;
        phase  <= '0;
      end
      // Every phase starts from a cleared accumulator and tap counter.
      if (in_hs || (out_hs && phase != PH_LAST)) begin
        mac_cnt <= '0;
        accum   <= '0;
      end else begin
        if (state == S_MAC) mac_cnt <= mac_cnt + 1'b1;
        if (prod_vld)       accum   <= accum + ACC_W'(prod);
      end
      if (state == S_MAC && mac_cnt == MAC_LAST) m_axis_tdata <= out_word;
      if (out_hs) begin
        if (phase == PH_LAST) ptr[ch_q] <= ptr[ch_q] + 1'b1;
        else                  phase     <= phase + 1'b1;
      end
    end
  end

endmodule
